// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: grants the lowest requesting bit at or above ptr,
// wrapping to bit 0 when nothing at or above ptr is requesting.
module arb_rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          vld
);
    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] src;

    always_comb begin
        mask   = ~((ONE << ptr) - ONE);
        masked = req & mask;
        src    = (|masked) ? masked : req;
        // Isolate the lowest set bit of the chosen request vector.
        gnt    = src & (~src + ONE);
        vld    = |req;
    end
endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter sharing one uart_tx core between N byte-stream requesters.
// A grant is held for a whole packet; a watchdog reclaims it if the owner stalls mid-packet.
module uart_tx_arb #(
    parameter int N         = 2,
    parameter int TIMEOUT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8*N-1:0]   req_data,
    input  logic [N-1:0]     req_valid,
    input  logic [N-1:0]     req_last,
    output logic [N-1:0]     req_ack,
    output logic [7:0]       uart_data,
    output logic             uart_valid,
    input  logic             uart_ack,
    output logic [N-1:0]     grant,
    output logic             timeout_stb
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOCK = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

    logic [1:0]           state_q, state_d;
    logic [N-1:0]         grant_q, grant_d;
    logic [N-1:0]         req_ack_q, req_ack_d;
    logic [7:0]           uart_data_q, uart_data_d;
    logic                 uart_valid_q, uart_valid_d;
    logic                 last_q, last_d;
    logic                 timeout_stb_q, timeout_stb_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;

    logic [N-1:0]         pick_gnt;
    logic                 pick_vld;
    logic [N-1:0]         cap_sel;
    logic [7:0]           cap_data;
    logic                 cap_last;
    logic [PW-1:0]        owner_idx;
    logic [PW-1:0]        rr_after_owner;
    logic [TIMEOUT_W-1:0] wd_inc;
    logic                 owner_valid;
    logic                 capture;
    logic                 wd_expire;
    logic                 send_done;
    logic [7:0]           req_byte [N];

    arb_rr_pick #(.N(N), .PW(PW)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .vld (pick_vld)
    );

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_byte
            assign req_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Capture source: a fresh winner when idle, otherwise only the current owner.
    always_comb begin
        cap_sel   = (state_q == ST_IDLE) ? pick_gnt : (grant_q & req_valid);
        cap_data  = '0;
        cap_last  = 1'b0;
        owner_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (cap_sel[i]) begin
                cap_data = cap_data | req_byte[i];
                cap_last = cap_last | req_last[i];
            end
            if (grant_q[i]) begin
                owner_idx = PW'(i);
            end
        end
        rr_after_owner = (owner_idx == PW'(N-1)) ? '0 : owner_idx + PW'(1);
        wd_inc         = wd_cnt_q + TIMEOUT_W'(1);
    end

    assign owner_valid = |(grant_q & req_valid);
    assign capture     = ((state_q == ST_IDLE) && pick_vld) || ((state_q == ST_LOCK) && owner_valid);
    assign wd_expire   = (state_q == ST_LOCK) && !owner_valid && (wd_inc == WD_MAX);
    assign send_done   = (state_q == ST_SEND) && uart_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            req_ack_q     <= '0;
            uart_data_q   <= '0;
            uart_valid_q  <= 1'b0;
            last_q        <= 1'b0;
            timeout_stb_q <= 1'b0;
            rr_ptr_q      <= '0;
            wd_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            req_ack_q     <= req_ack_d;
            uart_data_q   <= uart_data_d;
            uart_valid_q  <= uart_valid_d;
            last_q        <= last_d;
            timeout_stb_q <= timeout_stb_d;
            rr_ptr_q      <= rr_ptr_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (capture) state_d = ST_SEND;
            ST_LOCK: begin
                if (capture)        state_d = ST_SEND;
                else if (wd_expire) state_d = ST_IDLE;
            end
            ST_SEND: if (send_done) state_d = last_q ? ST_IDLE : ST_LOCK;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_d       = grant_q;
        req_ack_d     = '0;
        uart_data_d   = uart_data_q;
        uart_valid_d  = uart_valid_q;
        last_d        = last_q;
        timeout_stb_d = 1'b0;
        rr_ptr_d      = rr_ptr_q;
        wd_cnt_d      = wd_cnt_q;
        if (capture) begin
            grant_d      = (state_q == ST_IDLE) ? pick_gnt : grant_q;
            req_ack_d    = cap_sel;
            uart_data_d  = cap_data;
            uart_valid_d = 1'b1;
            last_d       = cap_last;
            wd_cnt_d     = '0;
        end else if (wd_expire) begin
            timeout_stb_d = 1'b1;
            grant_d       = '0;
            rr_ptr_d      = rr_after_owner;
            wd_cnt_d      = '0;
        end else if (state_q == ST_LOCK) begin
            wd_cnt_d = wd_inc;
        end
        if (send_done) begin
            uart_valid_d = 1'b0;
            wd_cnt_d     = '0;
            if (last_q) begin
                grant_d  = '0;
                rr_ptr_d = rr_after_owner;
            end
        end
    end

    assign req_ack     = req_ack_q;
    assign uart_data   = uart_data_q;
    assign uart_valid  = uart_valid_q;
    assign grant       = grant_q;
    assign timeout_stb = timeout_stb_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb (N=2, TIMEOUT_W=4) with a uart_tx model acking
// 3 cycles after uart_valid rises and queue-driven requesters that advance on req_ack.
module tb_uart_tx_arb;
    localparam int N  = 2;
    localparam int TW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req_data;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_last  = 2'b00;
    logic [1:0]  req_ack;
    logic [7:0]  uart_data;
    logic        uart_valid;
    logic        uart_ack;
    logic [1:0]  grant;
    logic        timeout_stb;

    logic        model_ack = 1'b0;
    logic        force_ack = 1'b0;
    logic [2:0]  model_cnt = 3'd0;
    logic [7:0]  d0 = 8'h00;
    logic [7:0]  d1 = 8'h00;
    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    logic [7:0]  acc[$];
    logic [1:0]  gseq[$];
    int          ack0_cnt = 0;
    int          ack1_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        chk_lock = 1'b0;
    int          lock_base = 0;
    logic        g10_early = 1'b0;

    assign uart_ack = model_ack | force_ack;
    assign req_data = {d1, d0};

    always #5 clk = ~clk;

    uart_tx_arb #(.N(N), .TIMEOUT_W(TW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_ack     (req_ack),
        .uart_data   (uart_data),
        .uart_valid  (uart_valid),
        .uart_ack    (uart_ack),
        .grant       (grant),
        .timeout_stb (timeout_stb)
    );

    // uart_tx model: ack is sampled on the third rising edge after uart_valid rises.
    always @(negedge clk) begin
        if (uart_valid) begin
            model_cnt <= model_cnt + 3'd1;
            model_ack <= (model_cnt == 3'd2);
        end else begin
            model_cnt <= 3'd0;
            model_ack <= 1'b0;
        end
    end

    // Requesters: present the queue head, drop it in the cycle req_ack is seen.
    always @(negedge clk) begin
        if (req_ack[0] && q0.size() > 0) void'(q0.pop_front());
        if (req_ack[1] && q1.size() > 0) void'(q1.pop_front());
        if (q0.size() > 0) begin
            req_valid[0] <= 1'b1;
            d0           <= q0[0][7:0];
            req_last[0]  <= q0[0][8];
        end else begin
            req_valid[0] <= 1'b0;
        end
        if (q1.size() > 0) begin
            req_valid[1] <= 1'b1;
            d1           <= q1[0][7:0];
            req_last[1]  <= q1[0][8];
        end else begin
            req_valid[1] <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (uart_valid && uart_ack) acc.push_back(uart_data);
        if (req_ack != 2'b00) gseq.push_back(grant);
        if (req_ack[0]) ack0_cnt <= ack0_cnt + 1;
        if (req_ack[1]) ack1_cnt <= ack1_cnt + 1;
        if (chk_lock && grant == 2'b10 && acc.size() < lock_base + 3) g10_early <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input logic lvl, input string tag);
        int n = 0;
        while (uart_valid !== lvl && n < 100) begin tick(); n++; end
        chk(tag, 32'(uart_valid), 32'(lvl));
    endtask

    task automatic wait_grant(input logic [1:0] g, input string tag);
        int n = 0;
        while (grant !== g && n < 200) begin tick(); n++; end
        chk(tag, 32'(grant), 32'(g));
    endtask

    task automatic wait_acc(input int target, input string tag);
        int n = 0;
        while (acc.size() < target && n < 300) begin tick(); n++; end
        chk(tag, 32'(acc.size() >= target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no end of run expected $finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int base, gb, a0, a1, c;
        logic [7:0] eb;
        tick(); tick();
        chk("rst_valid", 32'(uart_valid), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_data", 32'(uart_data), 32'd0);
        chk("rst_tmo", 32'(timeout_stb), 32'd0);
        rst = 1'b0;
        tick();

        // 1: single-byte packet from req0
        a0 = ack0_cnt; base = acc.size();
        q0.push_back({1'b1, 8'h41});
        tick();
        chk("t1_data", 32'(uart_data), 32'h41);
        chk("t1_valid", 32'(uart_valid), 32'd1);
        chk("t1_ack", 32'(req_ack), 32'b01);
        chk("t1_grant", 32'(grant), 32'b01);
        tick();
        chk("t1_ack_pulse", 32'(req_ack), 32'b00);
        chk("t1_grant_hold", 32'(grant), 32'b01);
        tick(); tick();
        chk("t1_grant_rel", 32'(grant), 32'b00);
        chk("t1_valid_rel", 32'(uart_valid), 32'd0);
        chk("t1_ack_cnt", 32'(ack0_cnt - a0), 32'd1);
        chk("t1_byte", 32'(acc[base]), 32'h41);

        // 2: packet lock, req1 held valid throughout
        base = acc.size(); lock_base = base; chk_lock = 1'b1;
        q0.push_back({1'b0, 8'h41}); q0.push_back({1'b0, 8'h42}); q0.push_back({1'b1, 8'h43});
        tick();
        q1.push_back({1'b1, 8'h5A});
        wait_acc(base + 4, "t2_wait");
        chk_lock = 1'b0;
        chk("t2_b0", 32'(acc[base]), 32'h41);
        chk("t2_b1", 32'(acc[base+1]), 32'h42);
        chk("t2_b2", 32'(acc[base+2]), 32'h43);
        chk("t2_b3", 32'(acc[base+3]), 32'h5A);
        chk("t2_no_early_g10", 32'(g10_early), 32'd0);
        wait_grant(2'b00, "t2_idle");

        // 3: round robin with both requesters always valid
        base = acc.size(); gb = gseq.size(); a0 = ack0_cnt; a1 = ack1_cnt;
        for (int k = 0; k < 4; k++) begin
            q0.push_back({1'b1, 8'hB0 + 8'(k)});
            q1.push_back({1'b1, 8'hC0 + 8'(k)});
        end
        wait_acc(base + 8, "t3_wait");
        for (int k = 0; k < 8; k++) begin
            eb = ((k % 2) == 0) ? (8'hB0 + 8'(k/2)) : (8'hC0 + 8'(k/2));
            chk($sformatf("t3_byte%0d", k), 32'(acc[base+k]), 32'(eb));
            chk($sformatf("t3_grant%0d", k), 32'(gseq[gb+k]), ((k % 2) == 0) ? 32'b01 : 32'b10);
        end
        wait_grant(2'b00, "t3_idle");
        chk("t3_ack0_cnt", 32'(ack0_cnt - a0), 32'd4);
        chk("t3_ack1_cnt", 32'(ack1_cnt - a1), 32'd4);

        // 4: watchdog breaks a stalled packet
        q0.push_back({1'b0, 8'h11});
        q1.push_back({1'b1, 8'h22});
        wait_valid(1'b1, "t4_start");
        chk("t4_data0", 32'(uart_data), 32'h11);
        chk("t4_grant0", 32'(grant), 32'b01);
        wait_valid(1'b0, "t4_lock");
        c = 0;
        while (!timeout_stb && c < 40) begin tick(); c++; end
        chk("t4_wd_cycles", 32'(c), 32'd15);
        chk("t4_grant_rel", 32'(grant), 32'b00);
        tick();
        chk("t4_tmo_pulse", 32'(timeout_stb), 32'd0);
        chk("t4_grant1", 32'(grant), 32'b10);
        chk("t4_data1", 32'(uart_data), 32'h22);
        chk("t4_ack1", 32'(req_ack), 32'b10);
        wait_grant(2'b00, "t4_idle");

        // 6: spurious uart_ack in IDLE and in LOCK
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        chk("t6_idle_grant", 32'(grant), 32'b00);
        chk("t6_idle_valid", 32'(uart_valid), 32'd0);
        chk("t6_idle_ack", 32'(req_ack), 32'b00);
        q0.push_back({1'b0, 8'h31});
        wait_valid(1'b1, "t6_start");
        wait_valid(1'b0, "t6_lock");
        force_ack = 1'b1;
        tick(); tick();
        force_ack = 1'b0;
        chk("t6_lock_grant", 32'(grant), 32'b01);
        chk("t6_lock_valid", 32'(uart_valid), 32'd0);
        chk("t6_lock_ack", 32'(req_ack), 32'b00);
        chk("t6_lock_tmo", 32'(timeout_stb), 32'd0);
        q0.push_back({1'b1, 8'h32});
        tick();
        chk("t6_data", 32'(uart_data), 32'h32);
        chk("t6_valid", 32'(uart_valid), 32'd1);
        chk("t6_ack", 32'(req_ack), 32'b01);
        wait_grant(2'b00, "t6_idle");

        // 5: asynchronous reset while a byte is in SEND
        base = acc.size();
        q0.push_back({1'b1, 8'h77});
        wait_valid(1'b1, "t5_start");
        chk("t5_grant0", 32'(grant), 32'b01);
        chk("t5_data0", 32'(uart_data), 32'h77);
        tick();
        chk("t5_still_send", 32'(uart_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(uart_valid), 32'd0);
        chk("t5_rst_grant", 32'(grant), 32'b00);
        chk("t5_rst_data", 32'(uart_data), 32'h00);
        chk("t5_rst_ack", 32'(req_ack), 32'b00);
        chk("t5_rst_tmo", 32'(timeout_stb), 32'd0);
        tick(); tick();
        rst = 1'b0;
        q1.push_back({1'b1, 8'h99});
        tick();
        chk("t5_grant1", 32'(grant), 32'b10);
        chk("t5_data1", 32'(uart_data), 32'h99);
        chk("t5_valid1", 32'(uart_valid), 32'd1);
        chk("t5_ack1", 32'(req_ack), 32'b10);
        wait_grant(2'b00, "t5_idle");
        chk("t5_acc_cnt", 32'(acc.size() - base), 32'd1);
        chk("t5_acc_byte", 32'(acc[base]), 32'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
